// File: rtl/wb_multi_counter.sv
// Wishbone-mapped bank of independent up/down counters with compare match,
// oneshot mode, per-channel interrupt enable and a selectable count output.
module wb_multi_counter #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [CHANNELS-1:0] la_load_en,
  input  logic [BITS-1:0]     la_load_val,
  output logic [BITS-1:0]     io_out,
  output logic [BITS-1:0]     io_oeb,
  output logic                irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } regSel_e;

  logic [3:0]      ctrl_q    [CHANNELS];
  logic [3:0]      ctrl_d    [CHANNELS];
  logic [BITS-1:0] count_q   [CHANNELS];
  logic [BITS-1:0] count_d   [CHANNELS];
  logic [BITS-1:0] compare_q [CHANNELS];
  logic [BITS-1:0] compare_d [CHANNELS];
  logic [CHANNELS-1:0] match_q, match_d;
  logic [3:0]  ioSel_q, ioSel_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        valid;
  regSel_e     rsel;
  logic        ioPage;
  logic [CHANNELS-1:0] hit, wrCtrl, wrCount, wrCompare, clrMatch, counting, atTerm, matchEv;
  logic [31:0] countMerged   [CHANNELS];
  logic [31:0] compareMerged [CHANNELS];
  logic        unused_adr;

  function automatic logic [31:0] zext(input logic [BITS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[BITS-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] sel);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = data[8*b +: 8];
    end
    return m;
  endfunction

  assign valid      = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign rsel       = regSel_e'(wbs_adr_i[3:2]);
  assign ioPage     = (wbs_adr_i[7:4] == 4'hF);
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  // Bus decode and per-channel next state; a COUNT write or LA load pre-empts counting,
  // so neither of them can raise a match.
  always_comb begin
    ack_d   = valid;
    dat_d   = '0;
    ioSel_d = ioSel_q;
    match_d = match_q;
    if (valid && ioPage && rsel == REG_CTRL) begin
      dat_d = {28'b0, ioSel_q};
      if (wbs_we_i && wbs_sel_i[0]) ioSel_d = wbs_dat_i[3:0];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c]           = valid && (wbs_adr_i[7:4] == 4'(c));
      wrCtrl[c]        = hit[c] && wbs_we_i && rsel == REG_CTRL && wbs_sel_i[0];
      wrCount[c]       = hit[c] && wbs_we_i && rsel == REG_COUNT && (|wbs_sel_i);
      wrCompare[c]     = hit[c] && wbs_we_i && rsel == REG_COMPARE && (|wbs_sel_i);
      clrMatch[c]      = hit[c] && wbs_we_i && rsel == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[0];
      countMerged[c]   = mergeBytes(zext(count_q[c]), wbs_dat_i, wbs_sel_i);
      compareMerged[c] = mergeBytes(zext(compare_q[c]), wbs_dat_i, wbs_sel_i);
      counting[c]      = ctrl_q[c][0] && !wrCount[c] && !la_load_en[c];
      atTerm[c]        = ctrl_q[c][1] ? (count_q[c] == '0) : (count_q[c] == compare_q[c]);
      matchEv[c]       = counting[c] && atTerm[c];

      if (hit[c]) begin
        case (rsel)
          REG_CTRL:    dat_d = {28'b0, ctrl_q[c]};
          REG_COUNT:   dat_d = zext(count_q[c]);
          REG_COMPARE: dat_d = zext(compare_q[c]);
          REG_STATUS:  dat_d = {31'b0, match_q[c]};
          default:     dat_d = '0;
        endcase
      end

      count_d[c] = count_q[c];
      if (wrCount[c])           count_d[c] = countMerged[c][BITS-1:0];
      else if (la_load_en[c])   count_d[c] = la_load_val;
      else if (ctrl_q[c][0]) begin
        if (ctrl_q[c][1]) count_d[c] = atTerm[c] ? compare_q[c] : count_q[c] - BITS'(1);
        else              count_d[c] = atTerm[c] ? '0 : count_q[c] + BITS'(1);
      end

      ctrl_d[c] = ctrl_q[c];
      if (wrCtrl[c])                          ctrl_d[c] = wbs_dat_i[3:0];
      else if (matchEv[c] && ctrl_q[c][2])    ctrl_d[c][0] = 1'b0;

      compare_d[c] = wrCompare[c] ? compareMerged[c][BITS-1:0] : compare_q[c];

      if (matchEv[c])       match_d[c] = 1'b1;
      else if (clrMatch[c]) match_d[c] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ioSel_q <= '0;
      match_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c]    <= '0;
        count_q[c]   <= '0;
        compare_q[c] <= '1;
      end
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ioSel_q <= ioSel_d;
      match_q <= match_d;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c]    <= ctrl_d[c];
        count_q[c]   <= count_d[c];
        compare_q[c] <= compare_d[c];
      end
    end
  end

  // A select value beyond the last channel matches nothing and leaves io_out at zero.
  always_comb begin
    io_out = '0;
    irq    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ioSel_q == 4'(c)) io_out = count_q[c];
      irq = irq | (match_q[c] & ctrl_q[c][3]);
    end
  end

  assign io_oeb    = {BITS{reset}};
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_multi_counter.sv
// Directed self-checking bench for wb_multi_counter: counting modes, match/irq,
// load priority, IO select, bus handshake and reset behaviour.
module tb_wb_multi_counter;

  localparam int CHANNELS = 4;
  localparam int BITS     = 16;

  logic clk = 1'b0;
  logic reset;
  logic wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [CHANNELS-1:0] la_load_en;
  logic [BITS-1:0] la_load_val;
  logic [BITS-1:0] io_out, io_oeb;
  logic irq;

  int checks = 0;
  int passes = 0;

  wb_multi_counter #(.CHANNELS(CHANNELS), .BITS(BITS)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_load_en(la_load_en), .la_load_val(la_load_val),
    .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus transfers return 1 ns after the acking edge with cyc/stb already dropped.
  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wbs_ack_o && n < 8);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (wbs_ack_o !== 1'b1) $display("[TB] FAIL wr_ack adr=%h: got ack %b required 1", adr, wbs_ack_o);
    else passes++;
  endtask

  task automatic wbRead(input logic [31:0] adr, output logic [31:0] data);
    int n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = adr; wbs_sel_i = 4'hF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wbs_ack_o && n < 8);
    data = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    checks++;
    if (wbs_ack_o !== 1'b1) $display("[TB] FAIL rd_ack adr=%h: got ack %b required 1", adr, wbs_ack_o);
    else passes++;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] expRd [5] = '{32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] adrs  [5] = '{32'h08, 32'h00, 32'h04, 32'h0C, 32'hF0};
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) $display("[TB] FAIL reset_bus: got ack %b dat %h required 0 0", wbs_ack_o, wbs_dat_o);
    else passes++;
    checks++;
    if (io_oeb !== 16'hFFFF) $display("[TB] FAIL reset_oeb: got %h required FFFF", io_oeb);
    else passes++;
    checks++;
    if (io_out !== 16'h0 || irq !== 1'b0) $display("[TB] FAIL reset_out: got io_out %h irq %b required 0 0", io_out, irq);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wbRead(adrs[i], rd);
      checks++;
      if (rd !== expRd[i]) $display("[TB] FAIL reset_reg adr=%h: got %h required %h", adrs[i], rd, expRd[i]);
      else passes++;
    end
  endtask

  task automatic test_up_wrap();
    logic [31:0] rd;
    logic [15:0] expSeq [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
    wbWrite(32'h08, 32'd3, 4'hF);
    wbWrite(32'h00, 32'h1, 4'hF);
    checks++;
    if (io_out !== 16'd0) $display("[TB] FAIL up_first_edge: got %h required 0", io_out);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (io_out !== expSeq[i]) $display("[TB] FAIL up_seq[%0d]: got %h required %h", i, io_out, expSeq[i]);
      else passes++;
    end
    wbRead(32'h0C, rd);
    checks++;
    if (rd !== 32'h1) $display("[TB] FAIL up_match: got %h required 1", rd);
    else passes++;
    wbWrite(32'h00, 32'h0, 4'hF);
    wbWrite(32'h04, 32'd7, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (io_out !== 16'd7) $display("[TB] FAIL disabled_hold: got %h required 0007", io_out);
    else passes++;
  endtask

  task automatic test_down_oneshot();
    logic [31:0] rd;
    logic [15:0] expSeq [5] = '{16'd1, 16'd0, 16'd5, 16'd5, 16'd5};
    wbWrite(32'h18, 32'd5, 4'hF);
    wbWrite(32'h14, 32'd2, 4'hF);
    wbWrite(32'hF0, 32'd1, 4'hF);
    wbWrite(32'h10, 32'h7, 4'hF);
    checks++;
    if (io_out !== 16'd2) $display("[TB] FAIL down_start: got %h required 0002", io_out);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (io_out !== expSeq[i]) $display("[TB] FAIL down_seq[%0d]: got %h required %h", i, io_out, expSeq[i]);
      else passes++;
    end
    wbRead(32'h10, rd);
    checks++;
    if (rd !== 32'h6) $display("[TB] FAIL oneshot_ctrl: got %h required 6", rd);
    else passes++;
    wbRead(32'h1C, rd);
    checks++;
    if (rd !== 32'h1) $display("[TB] FAIL down_match: got %h required 1", rd);
    else passes++;
  endtask

  task automatic test_irq_w1c();
    logic [31:0] rd;
    logic expIrq [2] = '{1'b0, 1'b1};
    wbWrite(32'h28, 32'd1, 4'hF);
    wbWrite(32'h20, 32'h9, 4'hF);
    checks++;
    if (irq !== 1'b0) $display("[TB] FAIL irq_idle: got %b required 0", irq);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq !== expIrq[i]) $display("[TB] FAIL irq_rise[%0d]: got %b required %b", i, irq, expIrq[i]);
      else passes++;
    end
    @(posedge clk); #1;
    wbWrite(32'h2C, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b1) $display("[TB] FAIL w1c_collide_irq: got %b required 1", irq);
    else passes++;
    wbRead(32'h2C, rd);
    checks++;
    if (rd !== 32'h1) $display("[TB] FAIL w1c_collide_flag: got %h required 1", rd);
    else passes++;
    wbWrite(32'h20, 32'h0, 4'hF);
    wbWrite(32'h2C, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b0) $display("[TB] FAIL w1c_clear_irq: got %b required 0", irq);
    else passes++;
    wbRead(32'h2C, rd);
    checks++;
    if (rd !== 32'h0) $display("[TB] FAIL w1c_clear_flag: got %h required 0", rd);
    else passes++;
  endtask

  task automatic test_load_priority();
    wbWrite(32'hF0, 32'd0, 4'hF);
    la_load_val = 16'h0020;
    la_load_en  = 4'b0001;
    wbWrite(32'h04, 32'h10, 4'hF);
    la_load_en = 4'b0000;
    checks++;
    if (io_out !== 16'h0010) $display("[TB] FAIL wb_over_la: got %h required 0010", io_out);
    else passes++;
    la_load_val = 16'h0033;
    la_load_en  = 4'b0001;
    @(posedge clk); #1;
    la_load_en = 4'b0000;
    checks++;
    if (io_out !== 16'h0033) $display("[TB] FAIL la_load: got %h required 0033", io_out);
    else passes++;
    wbWrite(32'h04, 32'h0000_ABCD, 4'b0010);
    checks++;
    if (io_out !== 16'hAB33) $display("[TB] FAIL sel_byte1: got %h required AB33", io_out);
    else passes++;
    wbWrite(32'h04, 32'hFFFF_0000, 4'b1100);
    checks++;
    if (io_out !== 16'hAB33) $display("[TB] FAIL sel_upper_discard: got %h required AB33", io_out);
    else passes++;
    wbWrite(32'h04, 32'h1234_5678, 4'hF);
    checks++;
    if (io_out !== 16'h5678) $display("[TB] FAIL width_trunc: got %h required 5678", io_out);
    else passes++;
  endtask

  task automatic test_io_select();
    logic [31:0] rd;
    wbWrite(32'hF0, 32'd1, 4'hF);
    checks++;
    if (io_out !== 16'd5 || io_oeb !== 16'h0) $display("[TB] FAIL io_sel1: got io_out %h oeb %h required 0005 0000", io_out, io_oeb);
    else passes++;
    wbWrite(32'hF0, 32'hE, 4'hF);
    checks++;
    if (io_out !== 16'h0) $display("[TB] FAIL io_sel_oob: got %h required 0000", io_out);
    else passes++;
    wbRead(32'hF0, rd);
    checks++;
    if (rd !== 32'hE) $display("[TB] FAIL io_sel_read: got %h required E", rd);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic expAck [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3C; wbs_sel_i = 4'hF;
    checks++;
    if (wbs_ack_o !== 1'b0) $display("[TB] FAIL b2b_ack_pre: got %b required 0", wbs_ack_o);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wbs_ack_o !== expAck[i] || (expAck[i] && wbs_dat_o !== 32'h0))
        $display("[TB] FAIL b2b_ack[%0d]: got ack %b dat %h required %b 0", i, wbs_ack_o, wbs_dat_o, expAck[i]);
      else passes++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wbRead(32'h40, rd);
    checks++;
    if (rd !== 32'h0) $display("[TB] FAIL unmapped_ch4: got %h required 0", rd);
    else passes++;
    wbRead(32'hF4, rd);
    checks++;
    if (rd !== 32'h0) $display("[TB] FAIL unmapped_f4: got %h required 0", rd);
    else passes++;
    wbWrite(32'hF8, 32'h3, 4'hF);
    wbRead(32'hF0, rd);
    checks++;
    if (rd !== 32'hE) $display("[TB] FAIL unmapped_write_side: got %h required E", rd);
    else passes++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h38; wbs_dat_i = 32'h55; wbs_sel_i = 4'hF;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wbs_ack_o !== 1'b0) $display("[TB] FAIL abort_ack_in_reset: got %b required 0", wbs_ack_o);
    else passes++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (io_oeb !== 16'hFFFF) $display("[TB] FAIL abort_oeb: got %h required FFFF", io_oeb);
    else passes++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wbs_ack_o !== 1'b0) $display("[TB] FAIL abort_no_ack[%0d]: got %b required 0", i, wbs_ack_o);
      else passes++;
    end
    wbRead(32'h38, rd);
    checks++;
    if (rd !== 32'h0000_FFFF) $display("[TB] FAIL abort_compare: got %h required FFFF", rd);
    else passes++;
    checks++;
    if (io_out !== 16'h0 || irq !== 1'b0) $display("[TB] FAIL abort_outputs: got io_out %h irq %b required 0 0", io_out, irq);
    else passes++;
  endtask

  initial begin
    reset = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    la_load_en = '0; la_load_val = '0;
    $display("[TB] starting wb_multi_counter bench");
    test_reset();
    test_up_wrap();
    test_down_oneshot();
    test_irq_w1c();
    test_load_priority();
    test_io_select();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_multi_counter.md
WB_MULTI_COUNTER -- requirements
Module: wb_multi_counter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent counter channels (legal range 1..15).
REQ-002 SHALL have parameter BITS, default 16, counter width per channel (legal range 2..32).
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, all input, 1 each: Wishbone cycle, strobe, write-enable.
REQ-006 SHALL have ports wbs_sel_i input 4, wbs_adr_i input 32, wbs_dat_i input 32: byte strobes, byte address, write data.
REQ-007 SHALL have ports wbs_ack_o output 1 and wbs_dat_o output 32: acknowledge and read data.
REQ-008 SHALL have ports la_load_en input CHANNELS and la_load_val input BITS: per-channel logic-analyzer load request and shared load value.
REQ-009 SHALL have ports io_out output BITS, io_oeb output BITS, irq output 1.

Function
REQ-010 Register map: adr[7:4]=channel c (0..CHANNELS-1), adr[3:2] selects CTRL(0), COUNT(1), COMPARE(2), STATUS(3); adr[7:4]=0xF, adr[3:2]=0 selects IO_SEL; adr[31:8] ignored.
REQ-011 CTRL bits: [0] enable, [1] down, [2] oneshot, [3] irq_en; other bits read 0.
REQ-012 Access valid = cyc & stb & !ack; wbs_ack_o SHALL pulse high exactly one cycle after valid, never on two consecutive cycles.
REQ-013 wbs_dat_o SHALL be registered alongside ack, zero-extended to 32 bits; unmapped addresses read 0, writes ignored, still acked.
REQ-014 Writes SHALL honour wbs_sel_i per byte; bytes above BITS discarded.
REQ-015 Enabled up-channel: count==compare -> count<=0 and match set; otherwise count<=count+1 (modulo 2^BITS).
REQ-016 Enabled down-channel: count==0 -> count<=compare and match set; otherwise count<=count-1.
REQ-017 Oneshot: on match, enable SHALL clear in same cycle; count still takes wrap/reload value.
REQ-018 COUNT update priority per channel: Wishbone COUNT write > la_load_en[c] (count<=la_load_val) > counting; loads do not set match.
REQ-019 STATUS[0] match flag: write 1 clears; a new match in same cycle as clear SHALL win (flag stays 1).
REQ-020 irq SHALL be combinational OR over channels of (match & irq_en).
REQ-021 io_out SHALL equal COUNT of channel IO_SEL[3:0]; IO_SEL >= CHANNELS gives io_out=0.
REQ-022 io_oeb SHALL be {BITS{reset}} (outputs driven whenever not in reset).
REQ-023 Disabled channel SHALL hold count; COMPARE changes take effect on next comparison.

Reset
REQ-024 While reset high: all COUNT, CTRL, STATUS, IO_SEL = 0, COMPARE = all ones, wbs_ack_o=0, wbs_dat_o=0.
REQ-025 Reset asserted mid-transaction SHALL abort it: no ack issued for that access after reset release.
REQ-026 First count edge SHALL occur no earlier than the cycle after a CTRL enable write is acked.

Verification
REQ-027 Ch0 COMPARE=3, CTRL=0x1 -> COUNT sequence 0,1,2,3,0; STATUS[0]=1 at wrap.
REQ-028 Ch1 COMPARE=5, COUNT=2, CTRL=0x7 (down, oneshot) -> 2,1,0,5 then holds 5, CTRL[0]=0, STATUS[0]=1.
REQ-029 Ch2 CTRL=0x9, COMPARE=1 -> irq rises on first match; W1C STATUS coincident with next match -> flag and irq remain 1.
REQ-030 Same cycle WB write COUNT=0x10 and la_load_en[0]=1 with la_load_val=0x20 -> COUNT=0x10.
REQ-031 IO_SEL=1 -> io_out tracks ch1; IO_SEL=0xE with CHANNELS=4 -> io_out=0; during reset io_oeb=0xFFFF.
REQ-032 Back-to-back held cyc/stb -> ack pattern 0,1,0,1; read of adr 0x3C returns 0.
